regfile_scrubber: RTL and testbench

- Read-side companion to the register bank: snoops every write into a private shadow copy, then on request walks the bank's read port and compares each returned word against the shadow.
- Flags mismatches caused by stuck or broken registers (fault-injection builds) and records the first failing entry.
- Sits beside the register file; owns the read-address mux only while busy.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/scrub_shadow.sv | 44 ++++
 rtl/regfile_scrubber.sv | 152 +++++++++++++++
 tb/tb_regfile_scrubber.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: constants shared by the register bank and its scrubber,
// plus the scrubber FSM state encoding.
package regfile_pkg;

  localparam int RF_WIDTH  = 8;
  localparam int RF_DEPTH  = 8;
  localparam int RF_ADDR_W = 3;
  localparam int RF_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } scrub_state_t;

endpackage

// File: rtl/scrub_shadow.sv
// scrub_shadow: private copy of the register bank built from snooped
// writes, with per-entry valid bits and one combinational read port.
// Ports: clk, reset (sync, active-high) | i_we/i_waddr/i_wdata snoop
// write | i_raddr read address | o_rdata/o_rvalid shadow word + valid.
module scrub_shadow
  import regfile_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata,
  output logic              o_rvalid
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic             w_wr_ok;
  logic             w_rd_ok;

  // Addresses beyond the bank are dropped.
  assign w_wr_ok = i_we && (int'(i_waddr) < DEPTH);
  assign w_rd_ok = int'(i_raddr) < DEPTH;

  // Data is deliberately not reset; the valid bits gate its use.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) r_vld <= '0;
    else if (w_wr_ok) r_vld[i_waddr] <= 1'b1;
  end

  assign o_rdata  = w_rd_ok ? r_mem[i_raddr] : '0;
  assign o_rvalid = w_rd_ok && r_vld[i_raddr];

endmodule

// File: rtl/regfile_scrubber.sv
// regfile_scrubber: walks the bank read port and compares each word
// against a snooped shadow copy, logging mismatches.
// Ports: clk, reset (sync, active-high), start | snoop_we/addr/data |
// rd_addr out, rd_data in (1-cycle latency) | busy, done | fault,
// fault_count, first_addr, first_exp, first_act.
// Build option: REGFILE_SCRUB_LOOP_EN = continuous scrubbing.
module regfile_scrubber
  import regfile_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int CNT_W  = RF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              snoop_we,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic [WIDTH-1:0]  snoop_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [CNT_W-1:0]  fault_count,
  output logic [ADDR_W-1:0] first_addr,
  output logic [WIDTH-1:0]  first_exp,
  output logic [WIDTH-1:0]  first_act
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  scrub_state_t      r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_busy;
  logic              r_done;

  logic              r_cmp_vld;
  logic [ADDR_W-1:0] r_cmp_addr;
  logic [WIDTH-1:0]  r_cmp_exp;

  logic              r_fault;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_first_addr;
  logic [WIDTH-1:0]  r_first_exp;
  logic [WIDTH-1:0]  r_first_act;

  logic [WIDTH-1:0]  w_sh_data;
  logic              w_sh_vld;
  logic              w_issue;
  logic              w_haz_issue;
  logic              w_haz_cmp;
  logic              w_mis;

  scrub_shadow #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_shadow (
    .clk      (clk),
    .reset    (reset),
    .i_we     (snoop_we),
    .i_waddr  (snoop_addr),
    .i_wdata  (snoop_data),
    .i_raddr  (r_ptr),
    .o_rdata  (w_sh_data),
    .o_rvalid (w_sh_vld)
  );

  assign w_issue     = (r_state == SCAN);
  // A write racing the capture or the compare makes the word ambiguous.
  assign w_haz_issue = snoop_we && (snoop_addr == r_ptr);
  assign w_haz_cmp   = snoop_we && (snoop_addr == r_cmp_addr);
  assign w_mis       = r_cmp_vld && !w_haz_cmp && (rd_data != r_cmp_exp);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= SCAN;
            r_busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (r_ptr == LAST) begin
            r_ptr   <= '0;
            r_state <= DRAIN;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        DRAIN: begin
          r_done <= 1'b1;
`ifdef REGFILE_SCRUB_LOOP_EN
          r_state <= SCAN;
`else
          r_state <= IDLE;
          r_busy  <= 1'b0;
`endif
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmp_vld    <= 1'b0;
      r_cmp_addr   <= '0;
      r_cmp_exp    <= '0;
      r_fault      <= 1'b0;
      r_cnt        <= '0;
      r_first_addr <= '0;
      r_first_exp  <= '0;
      r_first_act  <= '0;
    end else begin
      r_cmp_vld  <= w_issue && w_sh_vld && !w_haz_issue;
      r_cmp_addr <= r_ptr;
      r_cmp_exp  <= w_sh_data;
      if (w_mis) begin
        r_fault <= 1'b1;
        if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
        if (!r_fault) begin
          r_first_addr <= r_cmp_addr;
          r_first_exp  <= r_cmp_exp;
          r_first_act  <= rd_data;
        end
      end
    end
  end

  assign rd_addr     = r_ptr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign fault       = r_fault;
  assign fault_count = r_cnt;
  assign first_addr  = r_first_addr;
  assign first_exp   = r_first_exp;
  assign first_act   = r_first_act;

endmodule

// File: tb/tb_regfile_scrubber.sv
// tb_regfile_scrubber: random + directed bench for regfile_scrubber,
// with a behavioural bank (stuck-bit masks) and per-scan fault model.
module tb_regfile_scrubber;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          snoop_we = 1'b0;
  logic [AW-1:0] snoop_addr = '0;
  logic [W-1:0]  snoop_data = '0;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          busy;
  logic          done;
  logic          fault;
  logic [CW-1:0] fault_count;
  logic [AW-1:0] first_addr;
  logic [W-1:0]  first_exp;
  logic [W-1:0]  first_act;

  always #5 clk = ~clk;

  regfile_scrubber #(
    .WIDTH (W), .DEPTH (D), .ADDR_W (AW), .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .snoop_we    (snoop_we),
    .snoop_addr  (snoop_addr),
    .snoop_data  (snoop_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .fault_count (fault_count),
    .first_addr  (first_addr),
    .first_exp   (first_exp),
    .first_act   (first_act)
  );

  // Bank: registered read, stuck-at masks applied on the way out.
  logic [W-1:0] bank [D];
  logic [W-1:0] st0 [D];
  logic [W-1:0] st1 [D];

  always @(posedge clk) begin
    rd_data <= (bank[rd_addr] | st1[rd_addr]) & ~st0[rd_addr];
    if (snoop_we) bank[snoop_addr] <= snoop_data;
  end

  // Reference model
  logic [W-1:0]  m_sh [D];
  bit            m_vld [D];
  bit            m_fault;
  int            m_cnt;
  logic [AW-1:0] m_fa;
  logic [W-1:0]  m_fe;
  logic [W-1:0]  m_fact;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_vld[i] = 1'b0;
    m_fault = 1'b0;
    m_cnt   = 0;
    m_fa    = '0;
    m_fe    = '0;
    m_fact  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; snoop_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    snoop_we = 1'b1; snoop_addr = a; snoop_data = d;
    @(negedge clk);
    snoop_we = 1'b0;
    m_sh[a]  = d;
    m_vld[a] = 1'b1;
  endtask

  // One pass: every written, unraced address is read through the
  // faulty bank and compared, in ascending address order.
  task automatic predict(input bit hz, input logic [AW-1:0] h);
    logic [W-1:0] act;
    for (int a = 0; a < D; a++) begin
      if (!m_vld[a] || (hz && a == int'(h))) continue;
      act = (m_sh[a] | st1[a]) & ~st0[a];
      if (act != m_sh[a]) begin
        if (!m_fault) begin
          m_fa = AW'(a); m_fe = m_sh[a]; m_fact = act;
        end
        m_fault = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  endtask

  task automatic chk_state(input string tag);
    check({tag, "_fault"}, 32'(fault), 32'(m_fault));
    check({tag, "_cnt"}, 32'(fault_count), 32'(m_cnt));
    check({tag, "_faddr"}, 32'(first_addr), 32'(m_fa));
    check({tag, "_fexp"}, 32'(first_exp), 32'(m_fe));
    check({tag, "_fact"}, 32'(first_act), 32'(m_fact));
  endtask

  // pre: start already raised by caller. rk: cycle to pulse a stray
  // start. chain: raise start in the done cycle.
  task automatic scan(input bit pre, input bit hz,
                      input logic [AW-1:0] h, input bit off,
                      input logic [W-1:0] hd, input int rk,
                      input bit chain, output int lat);
    int k;
    bit seq_ok;
    bit got;
    predict(hz, h);
    if (!pre) begin
      @(negedge clk);
      start = 1'b1;
    end
    k = 0; seq_ok = 1'b1; got = 1'b0;
    while (!got && k < 30) begin
      @(negedge clk);
      k++;
      start = (rk != 0 && k == rk);
      if (hz && k == int'(h) + 1 + int'(off)) begin
        snoop_we = 1'b1; snoop_addr = h; snoop_data = hd;
      end else begin
        snoop_we = 1'b0;
      end
      if (k <= 8 && (rd_addr != AW'(k - 1) || !busy)) seq_ok = 1'b0;
      if (k == 9 && !busy) seq_ok = 1'b0;
      if (done) got = 1'b1;
    end
    lat = got ? k - 1 : -1;
    check("done_seen", 32'(got), 32'd1);
    check("rd_seq", 32'(seq_ok), 32'd1);
    if (hz) begin
      m_sh[h] = hd; m_vld[h] = 1'b1;
    end
    if (chain) start = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;
    int prev;
    int pulses;
    bit seen;
    bit hz;
    bit off;
    int nw;
    logic [AW-1:0] a;
    logic [AW-1:0] h;
    logic [W-1:0]  hd;

    for (int i = 0; i < D; i++) begin
      st0[i] = '0; st1[i] = '0; m_sh[i] = '0;
    end
    model_reset();
    do_reset();

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdaddr", 32'(rd_addr), 32'd0);
    chk_state("rst");

`ifndef REGFILE_SCRUB_LOOP_EN
    // Empty shadow: nothing compared.
    scan(0, 0, '0, 0, '0, 0, 0, lat);
    check("lat_empty", 32'(lat), 32'd9);
    check("busy_after", 32'(busy), 32'd0);
    chk_state("empty");
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);

    wr(3'd3, 8'hA5);
    wr(3'd5, 8'h3C);
    scan(0, 0, '0, 0, '0, 0, 0, lat);
    check("lat_clean", 32'(lat), 32'd9);
    chk_state("clean");

    wr(3'd2, 8'hFF);
    st0[2] = 8'h08;
    scan(0, 0, '0, 0, '0, 0, 0, lat);
    chk_state("stuck2");
    check("first_act_f7", 32'(first_act), 32'hF7);

    wr(3'd6, 8'h81);
    st0[6] = 8'h01;
    scan(0, 0, '0, 0, '0, 0, 0, lat);
    chk_state("stuck6");
    check("cnt3", 32'(fault_count), 32'd3);

    // Racing write on a broken entry must not count.
    wr(3'd4, 8'h22);
    st1[4] = 8'h80;
    scan(0, 1, 3'd4, 0, 8'h11, 0, 0, lat);
    chk_state("haz_iss");

    // Stray start mid-scan, then back-to-back scans.
    scan(0, 0, '0, 0, '0, 4, 1, lat);
    check("lat_stray", 32'(lat), 32'd9);
    chk_state("stray");
    scan(1, 0, '0, 0, '0, 0, 0, lat);
    check("lat_chain", 32'(lat), 32'd9);
    chk_state("chain");

    repeat (20) begin
      nw = int'($urandom_range(0, 3));
      for (int j = 0; j < nw; j++)
        wr(AW'($urandom_range(0, 7)), W'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        a = AW'($urandom_range(0, 7));
        st0[a] = W'(1 << $urandom_range(0, 7));
      end
      if ($urandom_range(0, 3) == 0) begin
        a = AW'($urandom_range(0, 7));
        st1[a] = W'(1 << $urandom_range(0, 7));
      end
      if ($urandom_range(0, 3) == 0) begin
        a = AW'($urandom_range(0, 7));
        st0[a] = '0; st1[a] = '0;
      end
      hz  = 1'($urandom_range(0, 1));
      h   = AW'($urandom_range(0, 7));
      off = 1'($urandom_range(0, 1));
      hd  = W'($urandom);
      scan(0, hz, h, off, hd, 0, 0, lat);
      check("lat_rnd", 32'(lat), 32'd9);
      chk_state("rnd");
    end

    // Every entry broken: counter must pin at all-ones.
    for (int i = 0; i < D; i++) begin
      wr(AW'(i), 8'h00);
      st0[i] = '0; st1[i] = 8'h01;
    end
    repeat (33) scan(0, 0, '0, 0, '0, 0, 0, lat);
    chk_state("sat");
    check("sat_cnt", 32'(fault_count), 32'd255);

    // Reset while address 5 is being issued.
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_addr5", 32'(rd_addr), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_rdaddr", 32'(rd_addr), 32'd0);
    chk_state("mid");
    reset = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("mid_nodone", 32'(seen), 32'd0);
    scan(0, 0, '0, 0, '0, 0, 0, lat);
    check("lat_post", 32'(lat), 32'd9);
    chk_state("post");
`else
    wr(3'd1, 8'h40);
    st0[1] = 8'h40;
    @(negedge clk);
    start = 1'b1;
    k = 0; prev = 0; pulses = 0;
    while (pulses < 3 && k < 40) begin
      @(negedge clk);
      k++;
      start = (k == 12);
      if (done) begin
        predict(0, '0);
        if (pulses == 0) check("loop_first", 32'(k - 1), 32'd9);
        else check("loop_period", 32'(k - prev), 32'd9);
        chk_state("loop");
        prev = k;
        pulses++;
      end
    end
    check("loop_pulses", 32'(pulses), 32'd3);
    check("loop_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk_state("loop_rst");
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("loop_nodone", 32'(seen), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
